// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2 / stride-2 max-pooling engine.
// The default-size localparams describe the 4x24x24 map this engine replaces.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_IN_H     = 24;
    localparam int DEF_IN_W     = 24;
    localparam int DEF_CH       = 4;
    localparam int DEF_DW       = 15;
    localparam int DEF_OH       = DEF_IN_H / 2;
    localparam int DEF_OW       = DEF_IN_W / 2;
    localparam int DEF_IN_BITS  = DEF_CH * DEF_IN_H * DEF_IN_W * DEF_DW;
    localparam int DEF_OUT_BITS = DEF_CH * DEF_OH * DEF_OW * DEF_DW;

    // LSB position of element (c,y,x) on a map bus of n_ch x h x w slots;
    // slot 0 sits at the MSB end of the bus.
    function automatic int slot_lsb(input int c, input int y, input int x,
                                    input int n_ch, input int h, input int w,
                                    input int dw);
        return (n_ch * h * w - 1 - ((c * h + y) * w + x)) * dw;
    endfunction

endpackage

// File: rtl/maxpool_win4.sv
// Combinational maximum of one 2x2 window.
// Build option MAXPOOL_RELU_EN: clamp negative maxima to zero (SIGNED=1 only).
module maxpool_win4
    import maxpool_pkg::*;
#(
    parameter int DW     = 15,
    parameter int SIGNED = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] max_val
);

    function automatic logic greater(input logic [DW-1:0] x, input logic [DW-1:0] y);
        if (SIGNED != 0) return $signed(x) > $signed(y);
        else             return x > y;
    endfunction

    logic [DW-1:0] max_ab;
    logic [DW-1:0] max_cd;

    // Two-level compare tree, with an optional clamp of negative results.
    always_comb begin
        max_ab  = greater(b, a) ? b : a;
        max_cd  = greater(d, c) ? d : c;
        max_val = greater(max_cd, max_ab) ? max_cd : max_ab;
`ifdef MAXPOOL_RELU_EN
        if (SIGNED != 0 && max_val[DW-1]) max_val = '0;
`endif
    end

endmodule

// File: rtl/maxpool2x2_param.sv
// 2x2 / stride-2 max-pooling engine: latches a full CH x IN_H x IN_W map on
// start and writes one pooled output row (all channels) per clock.
// Build option MAXPOOL_RELU_EN is handled inside maxpool_win4.
//
// state | meaning
// IDLE  | waiting for start_flag, out holds whatever was last written
// RUN   | writing pooled row `row` into out each cycle
// DONE  | out complete and held; end_flag high on the first DONE cycle
module maxpool2x2_param
    import maxpool_pkg::*;
#(
    parameter int IN_H   = 24,
    parameter int IN_W   = 24,
    parameter int CH     = 4,
    parameter int DW     = 15,
    parameter int SIGNED = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_flag,
    input  logic [CH*IN_H*IN_W*DW-1:0]            in,
    output logic [CH*(IN_H/2)*(IN_W/2)*DW-1:0]    out,
    output logic                                  busy,
    output logic                                  end_flag
);

    localparam int ROWS     = IN_H / 2;
    localparam int COLS     = IN_W / 2;
    localparam int IN_BITS  = CH * IN_H * IN_W * DW;
    localparam int OUT_BITS = CH * ROWS * COLS * DW;
    localparam int SEG      = COLS * DW;
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IIW      = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam int OIW      = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam int SIW      = (CH * SEG > 1) ? $clog2(CH * SEG) : 1;

    if ((IN_H % 2) != 0 || (IN_W % 2) != 0 || CH == 0) begin : g_param_check
        $error("maxpool2x2_param: IN_H and IN_W must be even and CH nonzero");
    end

    state_t             state;
    state_t             state_nx;
    logic [RW-1:0]      row;
    logic [IN_BITS-1:0] map_q;
    logic [CH*SEG-1:0]  row_vec;
    logic               last_row;
    logic               accept;

    assign last_row = (row == RW'(ROWS - 1));
    assign accept   = (state == IDLE || state == DONE) && start_flag;
    assign busy     = (state == RUN);

    // One pooling window per (channel, output column), reading map rows 2r and 2r+1.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar x = 0; x < COLS; x++) begin : g_col
            logic [IIW-1:0] i00, i01, i10, i11;
            assign i00 = IIW'(slot_lsb(c, 2 * int'(row),     2 * x,     CH, IN_H, IN_W, DW));
            assign i01 = IIW'(slot_lsb(c, 2 * int'(row),     2 * x + 1, CH, IN_H, IN_W, DW));
            assign i10 = IIW'(slot_lsb(c, 2 * int'(row) + 1, 2 * x,     CH, IN_H, IN_W, DW));
            assign i11 = IIW'(slot_lsb(c, 2 * int'(row) + 1, 2 * x + 1, CH, IN_H, IN_W, DW));

            maxpool_win4 #(
                .DW     (DW),
                .SIGNED (SIGNED)
            ) u_win (
                .a       (map_q[i00 +: DW]),
                .b       (map_q[i01 +: DW]),
                .c       (map_q[i10 +: DW]),
                .d       (map_q[i11 +: DW]),
                .max_val (row_vec[c*SEG + (COLS-1-x)*DW +: DW])
            );
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a start during RUN is dropped.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_flag) state_nx = RUN;
            RUN:     if (last_row)   state_nx = DONE;
            DONE:    if (start_flag) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Map capture, row counter, row write-back and end pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            row      <= '0;
            map_q    <= '0;
            out      <= '0;
            end_flag <= 1'b0;
        end else begin
            end_flag <= (state == RUN) && last_row;
            if (accept) begin
                map_q <= in;
                row   <= '0;
            end
            if (state == RUN) begin
                for (int c = 0; c < CH; c++) begin
                    out[OIW'(slot_lsb(c, int'(row), COLS - 1, CH, ROWS, COLS, DW)) +: SEG]
                        <= row_vec[SIW'(c * SEG) +: SEG];
                end
                row <= last_row ? '0 : row + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_param.sv
// Directed bench for maxpool2x2_param: default 4x24x24 map, 2x2 signed and
// unsigned single-window instances, and a 2x4x6 signed instance.
module tb_maxpool2x2_param;

    localparam int DIN  = 4 * 24 * 24 * 15;
    localparam int DOUT = 4 * 12 * 12 * 15;
    localparam int KIN  = 2 * 4 * 6 * 8;
    localparam int KOUT = 2 * 2 * 3 * 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic            d_start = 1'b0;
    logic [DIN-1:0]  d_in = '0;
    logic [DOUT-1:0] d_out;
    logic            d_busy, d_end;

    logic            s_start = 1'b0;
    logic [31:0]     s_in = '0;
    logic [7:0]      s_out;
    logic            s_busy, s_end;

    logic            u_start = 1'b0;
    logic [31:0]     u_in = '0;
    logic [7:0]      u_out;
    logic            u_busy, u_end;

    logic            k_start = 1'b0;
    logic [KIN-1:0]  k_in = '0;
    logic [KOUT-1:0] k_out;
    logic            k_busy, k_end;

    int n_run  = 0;
    int n_fail = 0;

    logic [DIN-1:0] map_a, map_b;

    always #5 clk = ~clk;

    maxpool2x2_param u_dflt (
        .clk(clk), .reset(reset), .start_flag(d_start), .in(d_in),
        .out(d_out), .busy(d_busy), .end_flag(d_end)
    );

    maxpool2x2_param #(.IN_H(2), .IN_W(2), .CH(1), .DW(8), .SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .start_flag(s_start), .in(s_in),
        .out(s_out), .busy(s_busy), .end_flag(s_end)
    );

    maxpool2x2_param #(.IN_H(2), .IN_W(2), .CH(1), .DW(8), .SIGNED(0)) u_uns (
        .clk(clk), .reset(reset), .start_flag(u_start), .in(u_in),
        .out(u_out), .busy(u_busy), .end_flag(u_end)
    );

    maxpool2x2_param #(.IN_H(4), .IN_W(6), .CH(2), .DW(8), .SIGNED(1)) u_small (
        .clk(clk), .reset(reset), .start_flag(k_start), .in(k_in),
        .out(k_out), .busy(k_busy), .end_flag(k_end)
    );

    function automatic int tb_lsb(int c, int y, int x, int n, int h, int w, int dw);
        return (n * h * w - 1 - ((c * h + y) * w + x)) * dw;
    endfunction

    // Map A counts up (window max bottom-right), map B counts down (max top-left).
    function automatic logic [DIN-1:0] mk_map(input bit use_b);
        logic [DIN-1:0] m;
        int v;
        m = '0;
        for (int c = 0; c < 4; c++)
            for (int y = 0; y < 24; y++)
                for (int x = 0; x < 24; x++) begin
                    v = c * 576 + y * 24 + x;
                    if (use_b) v = 5000 - v;
                    m[tb_lsb(c, y, x, 4, 24, 24, 15) +: 15] = 15'(v);
                end
        return m;
    endfunction

    function automatic int dflt_bad(input logic [DOUT-1:0] o, input bit use_b,
                                    output int f_idx, output int f_got, output int f_exp);
        int bad, e, g;
        bad = 0; f_idx = -1; f_got = 0; f_exp = 0;
        for (int c = 0; c < 4; c++)
            for (int oy = 0; oy < 12; oy++)
                for (int ox = 0; ox < 12; ox++) begin
                    if (use_b) e = 5000 - (c * 576 + 2 * oy * 24 + 2 * ox);
                    else       e = c * 576 + (2 * oy + 1) * 24 + 2 * ox + 1;
                    g = int'(o[tb_lsb(c, oy, ox, 4, 12, 12, 15) +: 15]);
                    if (g != e) begin
                        if (bad == 0) begin f_idx = (c * 12 + oy) * 12 + ox; f_got = g; f_exp = e; end
                        bad++;
                    end
                end
        return bad;
    endfunction

    // Start the default instance and follow it to end_flag; optionally re-pulse
    // start with another map at RUN cycle repulse_at. Returns on the end_flag cycle.
    task automatic run_dflt(input logic [DIN-1:0] map, input int repulse_at,
                            input logic [DIN-1:0] alt, output int lat, output int bcnt);
        int cyc;
        d_in = map; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        cyc = 0; bcnt = 0; lat = -1;
        while (cyc < 60 && lat < 0) begin
            cyc++;
            if (d_busy) bcnt++;
            if (d_end) lat = cyc;
            else begin
                if (cyc == repulse_at) begin d_start = 1'b1; d_in = alt; end
                else d_start = 1'b0;
                @(posedge clk); #1;
            end
        end
        d_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_run++; if (d_out !== '0)   begin n_fail++; $display("FAIL reset_out: got nonzero, expected 0"); end
        n_run++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", d_busy); end
        n_run++; if (d_end !== 1'b0)  begin n_fail++; $display("FAIL reset_end: got %b expected 0", d_end); end
        n_run++; if (k_out !== '0 || s_out !== 8'h00) begin n_fail++; $display("FAIL reset_small_out: got %h/%h expected 0", k_out, s_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_default();
        int lat, bc, bad, fi, fg, fe;
        run_dflt(map_a, -1, map_a, lat, bc);
        n_run++; if (lat !== 13) begin n_fail++; $display("FAIL dflt_latency: got %0d expected 13", lat); end
        n_run++; if (bc !== 12)  begin n_fail++; $display("FAIL dflt_busy_cycles: got %0d expected 12", bc); end
        bad = dflt_bad(d_out, 1'b0, fi, fg, fe);
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL dflt_out: %0d bad, slot %0d got %0d expected %0d", bad, fi, fg, fe); end
        repeat (3) @(posedge clk);
        #1;
        n_run++; if (d_end !== 1'b0 || d_busy !== 1'b0) begin n_fail++; $display("FAIL done_flags: end %b busy %b expected 0 0", d_end, d_busy); end
        bad = dflt_bad(d_out, 1'b0, fi, fg, fe);
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL done_hold: %0d bad, slot %0d got %0d expected %0d", bad, fi, fg, fe); end
    endtask

    task automatic test_restart_ignored();
        int lat, bc, bad, fi, fg, fe;
        run_dflt(map_b, 5, map_a, lat, bc);
        n_run++; if (lat !== 13) begin n_fail++; $display("FAIL restart_latency: got %0d expected 13", lat); end
        bad = dflt_bad(d_out, 1'b1, fi, fg, fe);
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL restart_out: %0d bad, slot %0d got %0d expected %0d", bad, fi, fg, fe); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        int lat, bc, bad, fi, fg, fe;
        d_in = map_a; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_run++; if (d_out !== '0)    begin n_fail++; $display("FAIL midrst_out: got nonzero expected 0"); end
        n_run++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", d_busy); end
        n_run++; if (d_end !== 1'b0)  begin n_fail++; $display("FAIL midrst_end: got %b expected 0", d_end); end
        run_dflt(map_b, -1, map_b, lat, bc);
        n_run++; if (lat !== 13) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 13", lat); end
        bad = dflt_bad(d_out, 1'b1, fi, fg, fe);
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_out2: %0d bad, slot %0d got %0d expected %0d", bad, fi, fg, fe); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc, bad, fi, fg, fe;
        run_dflt(map_a, -1, map_a, lat, bc);
        n_run++; if (lat !== 13) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 13", lat); end
        bad = dflt_bad(d_out, 1'b0, fi, fg, fe);
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_hold_first: %0d bad, slot %0d got %0d expected %0d", bad, fi, fg, fe); end
        run_dflt(map_b, -1, map_b, lat, bc);
        n_run++; if (lat !== 13) begin n_fail++; $display("FAIL b2b_latency2: got %0d expected 13", lat); end
        bad = dflt_bad(d_out, 1'b1, fi, fg, fe);
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_out2: %0d bad, slot %0d got %0d expected %0d", bad, fi, fg, fe); end
    endtask

    task automatic test_signed_window();
        int cyc, lat;
        logic [7:0] exp_v;
`ifdef MAXPOOL_RELU_EN
        exp_v = 8'h00;
`else
        exp_v = 8'hFF;
`endif
        s_in = 32'hFB80FFF9; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 0; lat = -1;
        while (cyc < 20 && lat < 0) begin
            cyc++;
            if (s_end) lat = cyc;
            else begin @(posedge clk); #1; end
        end
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL signed_latency: got %0d expected 2", lat); end
        n_run++; if (s_out !== exp_v) begin n_fail++; $display("FAIL signed_max: got %h expected %h", s_out, exp_v); end
    endtask

    task automatic test_unsigned_window();
        int cyc, lat;
        u_in = 32'hFB80FFF9; u_start = 1'b1;
        @(posedge clk); #1;
        u_start = 1'b0;
        cyc = 0; lat = -1;
        while (cyc < 20 && lat < 0) begin
            cyc++;
            if (u_end) lat = cyc;
            else begin @(posedge clk); #1; end
        end
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 2", lat); end
        n_run++; if (u_out !== 8'hFF) begin n_fail++; $display("FAIL unsigned_max: got %h expected ff", u_out); end
    endtask

    task automatic test_small_map(input int seed_run);
        logic [7:0] v [2][4][6];
        int cyc, lat, bad, fi, fg, fe, m, t;
        for (int c = 0; c < 2; c++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 6; x++) begin
                    v[c][y][x] = 8'($urandom_range(0, 255));
                    k_in[tb_lsb(c, y, x, 2, 4, 6, 8) +: 8] = v[c][y][x];
                end
        k_start = 1'b1;
        @(posedge clk); #1;
        k_start = 1'b0;
        cyc = 0; lat = -1;
        while (cyc < 20 && lat < 0) begin
            cyc++;
            if (k_end) lat = cyc;
            else begin @(posedge clk); #1; end
        end
        n_run++; if (lat !== 3) begin n_fail++; $display("FAIL small_latency run %0d: got %0d expected 3", seed_run, lat); end
        bad = 0; fi = -1; fg = 0; fe = 0;
        for (int c = 0; c < 2; c++)
            for (int oy = 0; oy < 2; oy++)
                for (int ox = 0; ox < 3; ox++) begin
                    m = -1000;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            t = int'($signed(v[c][2*oy+dy][2*ox+dx]));
                            if (t > m) m = t;
                        end
`ifdef MAXPOOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    t = int'($signed(k_out[tb_lsb(c, oy, ox, 2, 2, 3, 8) +: 8]));
                    if (t != m) begin
                        if (bad == 0) begin fi = (c * 2 + oy) * 3 + ox; fg = t; fe = m; end
                        bad++;
                    end
                end
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL small_out run %0d: %0d bad, slot %0d got %0d expected %0d", seed_run, bad, fi, fg, fe); end
        @(posedge clk); #1;
    endtask

    initial begin
        map_a = mk_map(1'b0);
        map_b = mk_map(1'b1);
        test_reset();
        test_default();
        test_restart_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_signed_window();
        test_unsigned_window();
        test_small_map(0);
        test_small_map(1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
